// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the fetch stage: default PC and
// bubble encoding, word width, FSM states and the wrapping PC increment.
package fetch_pkg;

    localparam int          WORD_W        = 32;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h5400_0000;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

    // Modulo-2^32 increment; 32'hFFFFFFFC wraps to 0 by truncation.
    function automatic logic [WORD_W-1:0] pc_inc(input logic [WORD_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: redirect load has priority over increment,
// otherwise the value is held. Asynchronous active-low reset to RESET_PC.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] load_pc,
    input  logic              incr,
    output logic [WORD_W-1:0] pc
);

    logic [WORD_W-1:0] pc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg <= RESET_PC;
        end else if (load) begin
            pc_reg <= load_pc;
        end else if (incr) begin
            pc_reg <= pc_inc(pc_reg);
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/fetch_control.sv
// Fetch stage control: PC, fetch/decode pipeline register and RUN/HOLD/FLUSH FSM.
// Optional stall/flush cycle counters are enabled by defining FETCH_STALL_STATS_EN.
module fetch_control
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEF,
    parameter int          FLUSH_DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        need_nop,
    input  logic        pc_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc_plus_4,
    output logic [31:0] decode_instr,
    output logic [31:0] decode_pc_plus_4,
`ifdef FETCH_STALL_STATS_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles,
`endif
    output logic        decode_valid
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_DEPTH - 1);

    fetch_state_t state_reg, state_next;
    logic [2:0]   cnt_reg, cnt_next;

    logic [31:0] dec_instr_reg, dec_instr_next;
    logic [31:0] dec_pc4_reg, dec_pc4_next;
    logic        dec_valid_reg, dec_valid_next;

    logic        pc_load;
    logic        pc_incr;
    logic [31:0] pc;

    fetch_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (pc_load),
        .load_pc(redirect_pc),
        .incr   (pc_incr),
        .pc     (pc)
    );

    assign imem_addr       = pc;
    assign fetch_pc_plus_4 = pc_inc(pc);
    assign fetch_instr     = (state_reg == ST_FLUSH) ? NOP_INSTR : imem_rdata;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        pc_load        = 1'b0;
        pc_incr        = 1'b0;
        dec_instr_next = fetch_instr;
        dec_pc4_next   = fetch_pc_plus_4;
        dec_valid_next = 1'b1;

        if (redirect_valid) begin
            pc_load        = 1'b1;
            dec_instr_next = NOP_INSTR;
            dec_pc4_next   = 32'd0;
            dec_valid_next = 1'b0;
            cnt_next       = FLUSH_INIT;
            state_next     = (FLUSH_DEPTH > 1) ? ST_FLUSH : ST_RUN;
        end else if (state_reg == ST_FLUSH) begin
            // Bubbles cannot create hazards, so hazard requests are ignored here.
            pc_incr        = 1'b1;
            dec_instr_next = NOP_INSTR;
            dec_pc4_next   = 32'd0;
            dec_valid_next = 1'b0;
            cnt_next       = cnt_reg - 3'd1;
            if (cnt_reg <= 3'd1) begin
                state_next = ST_RUN;
            end
        end else if (need_nop) begin
            dec_instr_next = NOP_INSTR;
            dec_pc4_next   = 32'd0;
            dec_valid_next = 1'b0;
            state_next     = ST_HOLD;
        end else if (pc_stall) begin
            // Re-latch the current fetch so the hazard unit sees equal PC+4 next cycle.
            state_next = ST_HOLD;
        end else begin
            pc_incr    = 1'b1;
            state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_RUN;
            cnt_reg       <= 3'd0;
            dec_instr_reg <= NOP_INSTR;
            dec_pc4_reg   <= 32'd0;
            dec_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            dec_instr_reg <= dec_instr_next;
            dec_pc4_reg   <= dec_pc4_next;
            dec_valid_reg <= dec_valid_next;
        end
    end

    assign decode_instr     = dec_instr_reg;
    assign decode_pc_plus_4 = dec_pc4_reg;
    assign decode_valid     = dec_valid_reg;

`ifdef FETCH_STALL_STATS_EN
    logic        flush_take;
    logic        stall_take;
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;

    assign flush_take = redirect_valid || (state_reg == ST_FLUSH);
    assign stall_take = !flush_take && (need_nop || pc_stall);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= 32'd0;
            flush_cnt_reg <= 32'd0;
        end else begin
            if (stall_take && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (flush_take && (flush_cnt_reg != 32'hFFFF_FFFF)) begin
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cnt_reg;
    assign flush_cycles = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control (FLUSH_DEPTH=2): vector table plus wrap and
// asynchronous-reset-during-flush sequences. Covers FETCH_STALL_STATS_EN when defined.
module tb_fetch_control;

    localparam logic [31:0] NOP = 32'h5400_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        need_nop = 1'b0;
    logic        pc_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc_plus_4;
    logic [31:0] decode_instr;
    logic [31:0] decode_pc_plus_4;
    logic        decode_valid;
`ifdef FETCH_STALL_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_cycles;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instruction memory model: contents derived from the address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign imem_rdata = mem(imem_addr);

    fetch_control #(
        .RESET_PC   (32'h0000_0000),
        .NOP_INSTR  (NOP),
        .FLUSH_DEPTH(2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .need_nop        (need_nop),
        .pc_stall        (pc_stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_rdata      (imem_rdata),
        .imem_addr       (imem_addr),
        .fetch_instr     (fetch_instr),
        .fetch_pc_plus_4 (fetch_pc_plus_4),
        .decode_instr    (decode_instr),
        .decode_pc_plus_4(decode_pc_plus_4),
`ifdef FETCH_STALL_STATS_EN
        .stall_cycles    (stall_cycles),
        .flush_cycles    (flush_cycles),
`endif
        .decode_valid    (decode_valid)
    );

    typedef struct {
        logic        nn;
        logic        ps;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] addr;     // imem_addr after the edge
        logic [31:0] dinstr;
        logic [31:0] dpc4;
        logic        dvalid;
        logic        flushing; // fetch_instr expected to be the bubble after the edge
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic nn, input logic ps, input logic rv,
                        input logic [31:0] rpc, input logic [31:0] addr,
                        input logic [31:0] dinstr, input logic [31:0] dpc4,
                        input logic dvalid, input logic flushing);
        vecs[i].nn = nn;   vecs[i].ps = ps;   vecs[i].rv = rv;   vecs[i].rpc = rpc;
        vecs[i].addr = addr; vecs[i].dinstr = dinstr; vecs[i].dpc4 = dpc4;
        vecs[i].dvalid = dvalid; vecs[i].flushing = flushing;
    endtask

    task automatic check_decode(input string tag, input logic [31:0] addr,
                                input logic [31:0] dinstr, input logic [31:0] dpc4,
                                input logic dvalid);
        chk({tag, " imem_addr"}, imem_addr, addr);
        chk({tag, " decode_instr"}, decode_instr, dinstr);
        chk({tag, " decode_pc_plus_4"}, decode_pc_plus_4, dpc4);
        chk({tag, " decode_valid"}, {31'd0, decode_valid}, {31'd0, dvalid});
    endtask

    initial begin
        // nn ps rv rpc        addr         dinstr             dpc4         v  flush
        setv( 0, 0, 0, 0, 32'h0,   32'h04,  mem(32'h00),  32'h04,  1, 0);
        setv( 1, 0, 0, 0, 32'h0,   32'h08,  mem(32'h04),  32'h08,  1, 0);
        setv( 2, 0, 0, 0, 32'h0,   32'h0C,  mem(32'h08),  32'h0C,  1, 0);
        setv( 3, 0, 0, 0, 32'h0,   32'h10,  mem(32'h0C),  32'h10,  1, 0);
        setv( 4, 1, 1, 0, 32'h0,   32'h10,  NOP,          32'h00,  0, 0); // load-use
        setv( 5, 0, 0, 0, 32'h0,   32'h14,  mem(32'h10),  32'h14,  1, 0);
        setv( 6, 0, 0, 0, 32'h0,   32'h18,  mem(32'h14),  32'h18,  1, 0);
        setv( 7, 0, 0, 0, 32'h0,   32'h1C,  mem(32'h18),  32'h1C,  1, 0);
        setv( 8, 0, 0, 0, 32'h0,   32'h20,  mem(32'h1C),  32'h20,  1, 0);
        setv( 9, 0, 1, 0, 32'h0,   32'h20,  mem(32'h20),  32'h24,  1, 0); // branch in fetch
        setv(10, 0, 0, 0, 32'h0,   32'h24,  mem(32'h20),  32'h24,  1, 0);
        setv(11, 0, 1, 1, 32'h100, 32'h100, NOP,          32'h00,  0, 1); // redirect + stall
        setv(12, 1, 0, 0, 32'h0,   32'h104, NOP,          32'h00,  0, 0); // FLUSH ignores nn
        setv(13, 0, 0, 0, 32'h0,   32'h108, mem(32'h104), 32'h108, 1, 0);
        setv(14, 1, 0, 0, 32'h0,   32'h108, NOP,          32'h00,  0, 0);
        setv(15, 1, 0, 0, 32'h0,   32'h108, NOP,          32'h00,  0, 0); // HOLD persists
        setv(16, 0, 0, 0, 32'h0,   32'h10C, mem(32'h108), 32'h10C, 1, 0);
        setv(17, 1, 0, 1, 32'h40,  32'h40,  NOP,          32'h00,  0, 1); // redirect + nn
        setv(18, 0, 1, 0, 32'h0,   32'h44,  NOP,          32'h00,  0, 0); // FLUSH ignores ps
        setv(19, 0, 0, 0, 32'h0,   32'h48,  mem(32'h44),  32'h48,  1, 0);

        // Reset state while rst_n is low.
        #12;
        check_decode("reset", 32'h0, NOP, 32'h0, 1'b0);
        chk("reset fetch_pc_plus_4", fetch_pc_plus_4, 32'h4);
        chk("reset fetch_instr", fetch_instr, mem(32'h0));
`ifdef FETCH_STALL_STATS_EN
        chk("reset stall_cycles", stall_cycles, 32'd0);
        chk("reset flush_cycles", flush_cycles, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            need_nop       = vecs[i].nn;
            pc_stall       = vecs[i].ps;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            @(posedge clk);
            #1;
            check_decode($sformatf("vec%0d", i), vecs[i].addr, vecs[i].dinstr,
                         vecs[i].dpc4, vecs[i].dvalid);
            chk($sformatf("vec%0d fetch_instr", i), fetch_instr,
                vecs[i].flushing ? NOP : mem(vecs[i].addr));
            $display("vec %0d nn=%0b ps=%0b rv=%0b addr=%h dinstr=%h dpc4=%h dvalid=%0b",
                     i, vecs[i].nn, vecs[i].ps, vecs[i].rv, imem_addr, decode_instr,
                     decode_pc_plus_4, decode_valid);
            @(negedge clk);
        end
        need_nop = 1'b0; pc_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;

`ifdef FETCH_STALL_STATS_EN
        chk("stats stall_cycles", stall_cycles, 32'd4);
        chk("stats flush_cycles", flush_cycles, 32'd4);
`endif

        // Wrap: redirect to 0xFFFFFFF8, one flush cycle, then run through 0xFFFFFFFC.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        @(posedge clk); #1;
        chk("wrap redirect addr", imem_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        redirect_valid = 1'b0; redirect_pc = 32'd0;
        @(posedge clk); #1;
        check_decode("wrap flush", 32'hFFFF_FFFC, NOP, 32'h0, 1'b0);
        chk("wrap fetch_pc_plus_4", fetch_pc_plus_4, 32'h0);
        @(posedge clk); #1;
        check_decode("wrap run", 32'h0, mem(32'hFFFF_FFFC), 32'h0, 1'b1);
        $display("wrap addr=%h dinstr=%h dpc4=%h dvalid=%0b",
                 imem_addr, decode_instr, decode_pc_plus_4, decode_valid);

        // Asynchronous reset in the middle of a flush.
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(posedge clk); #1;
        redirect_valid = 1'b0; redirect_pc = 32'd0;
        chk("midflush fetch_instr", fetch_instr, NOP);
        #2;
        rst_n = 1'b0;
        #1;
        check_decode("async reset", 32'h0, NOP, 32'h0, 1'b0);
        chk("async reset fetch_instr", fetch_instr, mem(32'h0));
`ifdef FETCH_STALL_STATS_EN
        chk("async reset stall_cycles", stall_cycles, 32'd0);
        chk("async reset flush_cycles", flush_cycles, 32'd0);
`endif
        $display("async reset addr=%h dinstr=%h dvalid=%0b", imem_addr, decode_instr, decode_valid);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_decode("post reset", 32'h4, mem(32'h0), 32'h4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
